vc_credit_tx: RTL and testbench
===============================

Name: vc_credit_tx

Overview:
- Upstream transmit side of a router link. It sends flits into the downstream per-VC input FIFOs, which are `BUF_DEPTH` deep.
- It keeps one credit counter per virtual channel and only forwards a flit when the target VC holds at least one credit.
- The downstream end returns one credit per FIFO pop.
- It sits between the switch-allocator output and the physical link, and registers the link outputs for one cycle of latency.

Parameters:
- NUM_VCS, 4, number of virtual channels on the link.
- BUF_DEPTH, 8, depth of each downstream VC FIFO; this is the initial credit count per VC.
- DATA_WIDTH, `FLIT_DATA_WIDTH, flit payload width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- in_valid  input  1  a flit is offered by the switch/allocator.
- in_vc  input  VC_W=$clog2(NUM_VCS)  target VC of the offered flit.
- in_data  input  DATA_WIDTH  offered flit payload.
- in_ready  output  1  the offered flit is accepted this cycle.
- credit_valid  input  1  the downstream end returns one credit.
- credit_vc  input  VC_W  VC the returned credit belongs to.
- link_valid  output  1  a flit is on the link this cycle.
- link_vc  output  VC_W  VC of the link flit.
- link_data  output  DATA_WIDTH  link flit payload.
- credit_avail  output  NUM_VCS  per-VC flag: credit count is non-zero.
- credit_err  output  1  sticky flag: a credit was returned to a VC that was already at BUF_DEPTH.

Behaviour:
- Reset (async, reset==0):
  - Every credit counter is set to BUF_DEPTH.
  - link_valid=0, link_vc=0, link_data=0, credit_err=0.
  - These take effect immediately, not at a clock edge; any flit in flight in the output register is dropped.
- Counter width: CW=$clog2(BUF_DEPTH+1), unsigned. Counters never wrap.
- credit_avail[v] = (cnt[v] != 0). This is combinational from the registered counters.
- in_ready = credit_avail[in_vc] && (in_vc < NUM_VCS).
  - Purely combinational from the counters and in_vc.
  - A credit returned in the same cycle does NOT raise in_ready; it becomes usable the next cycle.
- Accept = in_valid && in_ready. On the accepting edge:
  - link_valid<=1, link_vc<=in_vc, link_data<=in_data.
  - The flit appears on the link exactly 1 cycle after acceptance.
- No accept on an edge: link_valid<=0. link_vc and link_data hold their previous values. link_valid is high for exactly one cycle per accepted flit.
- Per-VC counter update each edge:
  - dec = accept && in_vc==v.
  - inc = credit_valid && credit_vc==v.
  - dec only: cnt-1 (dec is only possible when cnt≥1).
  - inc only: cnt+1, unless cnt==BUF_DEPTH. In that case cnt holds and credit_err<=1.
  - dec and inc together (same VC, same cycle): cnt unchanged, credit_err unaffected.
  - Neither: hold.
- credit_vc ≥ NUM_VCS while credit_valid=1: the return is ignored and credit_err<=1.
- credit_err clears only on reset.
- Throughput: one flit per cycle, sustained, while credits exist. Credit-return latency is not modelled internally; correctness relies only on the counters.
- Invariant (for the checker): for each VC, cnt + downstream occupancy + flits in flight (link register and credit wire) == BUF_DEPTH.

Decomposition:
- Shared package `noc_pkg`:
  - localparam VC_W;
  - typedef vc_id_t (logic [VC_W-1:0]);
  - typedef flit_t (logic [DATA_WIDTH-1:0]);
  - default BUF_DEPTH, equal to the FIFO depth used by the input ports.
- One sub-module `credit_counter`:
  - parameters MAX, CW; inputs inc and dec; outputs cnt, nonzero, overflow.
  - Instantiated NUM_VCS times with a generate loop.
- The top level holds the VC decode, the accept logic, the output register and the sticky error flag.

Test Plan:
- Reset release, then idle → credit_avail=4'b1111, each cnt==8, link_valid=0, credit_err=0.
- in_valid=1, in_vc=0 for 10 cycles, no credits returned:
  - in_ready is high for 8 cycles, then 0.
  - link_valid pulses 8 times, 1 cycle after each accept.
  - credit_avail[0]=0; VCs 1–3 unchanged.
- VC0 at cnt=0, credit_valid=1, credit_vc=0 with in_valid=1 on VC0 in the same cycle:
  - in_ready=0 in that cycle.
  - Next cycle cnt=1, in_ready=1, and the flit is accepted.
- VC2 at cnt=3, accept on VC2 and credit return on VC2 in the same cycle → cnt stays 3, credit_err=0.
- VC1 at cnt=8, credit_valid=1, credit_vc=1 → cnt stays 8, credit_err=1 and holds until reset.
- Accept a flit on VC3, then assert reset=0 mid-cycle before the next edge:
  - link_valid drops to 0 immediately, without waiting for a clock edge.
  - After release, every cnt==8.

Source files
------------

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared router-link types and default sizes
//
// Contents:
//   FLIT_DATA_WIDTH  default flit payload width
//   NUM_VCS          default number of virtual channels per link
//   VC_W             width of a VC identifier
//   BUF_DEPTH        default depth of a downstream per-VC input FIFO
//   vc_id_t, flit_t  VC identifier and flit payload types
package noc_pkg;

    localparam int FLIT_DATA_WIDTH = 32;
    localparam int NUM_VCS         = 4;
    localparam int VC_W            = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
    localparam int BUF_DEPTH       = 8;

    typedef logic [VC_W-1:0]            vc_id_t;
    typedef logic [FLIT_DATA_WIDTH-1:0] flit_t;

endpackage

// File: rtl/vc_credit_tx_if.sv
// rtl/vc_credit_tx_if.sv - flit, credit-return and link signals of the credit transmitter
//
// Signals:
//   in_valid/in_vc/in_data/in_ready   flit offered by the switch allocator
//   credit_valid/credit_vc            credit returned by the downstream end
//   link_valid/link_vc/link_data      registered flit on the physical link
//   credit_avail                      per-VC "credit count is non-zero"
//   credit_err                        sticky credit overflow / bad-VC return flag
// Modports:
//   slave   the transmitter itself
//   master  the surrounding environment (allocator, link, downstream credits)
interface vc_credit_tx_if
    import noc_pkg::*;
#(
    parameter int NUM_VCS    = noc_pkg::NUM_VCS,
    parameter int VC_W       = noc_pkg::VC_W,
    parameter int DATA_WIDTH = FLIT_DATA_WIDTH
);
    logic                  in_valid;
    logic [VC_W-1:0]       in_vc;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  credit_valid;
    logic [VC_W-1:0]       credit_vc;
    logic                  link_valid;
    logic [VC_W-1:0]       link_vc;
    logic [DATA_WIDTH-1:0] link_data;
    logic [NUM_VCS-1:0]    credit_avail;
    logic                  credit_err;

    modport slave (
        input  in_valid, in_vc, in_data, credit_valid, credit_vc,
        output in_ready, link_valid, link_vc, link_data, credit_avail, credit_err
    );

    modport master (
        output in_valid, in_vc, in_data, credit_valid, credit_vc,
        input  in_ready, link_valid, link_vc, link_data, credit_avail, credit_err
    );
endinterface

// File: rtl/vc_credit_tx_credit_counter.sv
// rtl/vc_credit_tx_credit_counter.sv - saturating credit counter for one virtual channel
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset, loads MAX
//   inc       one credit returned this cycle
//   dec       one credit consumed this cycle (only asserted when cnt != 0)
//   cnt       current credit count
//   nonzero   cnt != 0
//   overflow  a lone return arrived while already holding MAX credits
module credit_counter #(
    parameter int MAX = 8,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          nonzero,
    output logic          overflow
);

    logic at_max;

    assign at_max   = (cnt == CW'(MAX));
    assign nonzero  = (cnt != '0);
    // A simultaneous consume cancels the return, so only a lone return can overflow.
    assign overflow = inc && !dec && at_max;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= CW'(MAX);
        end else if (inc && !dec && !at_max) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && nonzero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/vc_credit_tx.sv
// rtl/vc_credit_tx.sv - credit-based virtual-channel transmitter for one router link
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset; refills all credits, clears link and error
//   bus    vc_credit_tx_if.slave: flit input (valid/vc/data/ready), credit return
//          (valid/vc), registered link output (valid/vc/data), credit_avail, credit_err
// A flit is accepted only when its VC holds a credit and appears on the link one
// cycle later. Credits returned in a cycle become usable on the following cycle.
module vc_credit_tx
    import noc_pkg::*;
#(
    parameter int NUM_VCS    = noc_pkg::NUM_VCS,
    parameter int BUF_DEPTH  = noc_pkg::BUF_DEPTH,
    parameter int DATA_WIDTH = FLIT_DATA_WIDTH
) (
    input  logic clk,
    input  logic reset,
    vc_credit_tx_if.slave bus
);

    localparam int VC_W    = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
    localparam int VC_SPAN = 1 << VC_W;
    localparam int CW      = $clog2(BUF_DEPTH + 1);

    logic [NUM_VCS-1:0]    inc;
    logic [NUM_VCS-1:0]    dec;
    logic [NUM_VCS-1:0]    nonzero;
    logic [NUM_VCS-1:0]    overflow;
    logic [VC_SPAN-1:0]    avail_pad;
    logic                  in_range;
    logic                  credit_in_range;
    logic                  accept;

    logic                  link_valid_q;
    logic [VC_W-1:0]       link_vc_q;
    logic [DATA_WIDTH-1:0] link_data_q;
    logic                  credit_err_q;

    // When NUM_VCS fills the VC id space every id is legal; otherwise the
    // unused ids must be screened off.
    generate
        if (NUM_VCS == VC_SPAN) begin : g_full_span
            assign in_range        = 1'b1;
            assign credit_in_range = 1'b1;
        end else begin : g_part_span
            assign in_range        = ({1'b0, bus.in_vc}     < (VC_W + 1)'(NUM_VCS));
            assign credit_in_range = ({1'b0, bus.credit_vc} < (VC_W + 1)'(NUM_VCS));
        end
    endgenerate

    // Padded so an out-of-range in_vc indexes a defined zero bit.
    assign avail_pad        = VC_SPAN'(nonzero);
    assign bus.credit_avail = nonzero;
    assign bus.in_ready     = avail_pad[bus.in_vc] && in_range;
    assign accept           = bus.in_valid && bus.in_ready;

    generate
        for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
            logic [CW-1:0] cnt_v;

            assign dec[v] = accept && (bus.in_vc == VC_W'(v));
            assign inc[v] = bus.credit_valid && (bus.credit_vc == VC_W'(v));

            credit_counter #(
                .MAX (BUF_DEPTH),
                .CW  (CW)
            ) u_credit_counter (
                .clk      (clk),
                .reset    (reset),
                .inc      (inc[v]),
                .dec      (dec[v]),
                .cnt      (cnt_v),
                .nonzero  (nonzero[v]),
                .overflow (overflow[v])
            );

            a_cnt_bounded: assert property (@(posedge clk) disable iff (!reset)
                cnt_v <= CW'(BUF_DEPTH));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            link_valid_q <= 1'b0;
            link_vc_q    <= '0;
            link_data_q  <= '0;
            credit_err_q <= 1'b0;
        end else begin
            link_valid_q <= accept;
            if (accept) begin
                link_vc_q   <= bus.in_vc;
                link_data_q <= bus.in_data;
            end
            if ((|overflow) || (bus.credit_valid && !credit_in_range)) begin
                credit_err_q <= 1'b1;
            end
        end
    end

    assign bus.link_valid = link_valid_q;
    assign bus.link_vc    = link_vc_q;
    assign bus.link_data  = link_data_q;
    assign bus.credit_err = credit_err_q;

endmodule

// File: tb/tb_vc_credit_tx.sv
// tb/tb_vc_credit_tx.sv - self-checking bench for vc_credit_tx
module tb_vc_credit_tx;
    import noc_pkg::*;

    localparam int NV    = 4;
    localparam int DEPTH = 8;

    logic clk;
    logic reset;

    vc_credit_tx_if #(.NUM_VCS(NV), .VC_W(2), .DATA_WIDTH(32)) bus ();

    vc_credit_tx #(
        .NUM_VCS    (NV),
        .BUF_DEPTH  (DEPTH),
        .DATA_WIDTH (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors;
    int          miscompares;

    // Reference model: credits held per VC, sticky error, expected link register.
    int          mcnt [NV];
    bit          merr;
    bit          exp_lv;
    int          exp_vc;
    logic [31:0] exp_data;

    typedef struct {
        bit iv;
        int vc;
        bit cv;
        int cvc;
        bit exp_rdy;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) mcnt[v] = DEPTH;
        merr     = 1'b0;
        exp_lv   = 1'b0;
        exp_vc   = 0;
        exp_data = '0;
    endtask

    // One clock cycle: apply inputs, check combinational outputs at the negedge,
    // advance the model, then check registered outputs just after the posedge.
    task automatic cycle(input bit iv, input int vc, input logic [31:0] d,
                         input bit cv, input int cvc, output bit rdy);
        bit         exp_rdy;
        bit         acc;
        logic [3:0] exp_avail;
        int         n;
        bus.in_valid     = iv;
        bus.in_vc        = vc[1:0];
        bus.in_data      = d;
        bus.credit_valid = cv;
        bus.credit_vc    = cvc[1:0];
        @(negedge clk);
        exp_rdy = (mcnt[vc] > 0);
        for (int v = 0; v < NV; v++) exp_avail[v] = (mcnt[v] > 0);
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("credit_avail", bus.credit_avail, exp_avail);
        rdy = bus.in_ready;
        acc = iv && exp_rdy;
        for (int v = 0; v < NV; v++) begin
            n = mcnt[v] - ((acc && vc == v) ? 1 : 0) + ((cv && cvc == v) ? 1 : 0);
            if (n > DEPTH) begin
                merr = 1'b1;
                n    = DEPTH;
            end
            mcnt[v] = n;
        end
        if (acc) begin
            exp_lv   = 1'b1;
            exp_vc   = vc;
            exp_data = d;
        end else begin
            exp_lv = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("link_valid", bus.link_valid, exp_lv);
        chk("link_vc", bus.link_vc, exp_vc[1:0]);
        chk("link_data", bus.link_data, exp_data);
        chk("credit_err", bus.credit_err, merr);
    endtask

    initial begin
        bit rdy;
        int cnt_ok;
        int pulses;

        vectors          = 0;
        miscompares      = 0;
        reset            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_vc        = '0;
        bus.in_data      = '0;
        bus.credit_valid = 1'b0;
        bus.credit_vc    = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("reset_link_valid", bus.link_valid, 1'b0);
        chk("reset_credit_err", bus.credit_err, 1'b0);
        reset = 1'b1;

        // Idle after reset release.
        cycle(0, 0, 32'h0, 0, 0, rdy);
        chk("idle_avail", bus.credit_avail, 4'b1111);

        // Drain VC0, then credit return racing an offer on the empty VC.
        for (int i = 0; i < 10; i++) tbl[i] = '{1'b1, 0, 1'b0, 0, (i < 8)};
        tbl[10] = '{1'b1, 0, 1'b1, 0, 1'b0};
        tbl[11] = '{1'b1, 0, 1'b0, 0, 1'b1};
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].iv, tbl[i].vc, 32'hA000 + i, tbl[i].cv, tbl[i].cvc, rdy);
            chk("tbl_ready", rdy, tbl[i].exp_rdy);
            if (i < 10 && bus.link_valid) pulses++;
            if (i == 9) chk("drained_avail", bus.credit_avail, 4'b1110);
        end
        chk("drain_pulses", pulses, 8);

        // VC2 down to 3 credits, then consume and return on VC2 together.
        for (int i = 0; i < 5; i++) cycle(1, 2, 32'hB000 + i, 0, 0, rdy);
        cycle(1, 2, 32'hB0FF, 1, 2, rdy);
        chk("vc2_same_cycle_ready", rdy, 1'b1);
        cnt_ok = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 2, 32'hB100 + i, 0, 0, rdy);
            if (rdy) cnt_ok++;
        end
        chk("vc2_remaining", cnt_ok, 3);

        // Randomised traffic with legal credit returns only.
        for (int i = 0; i < 1500; i++) begin
            int rvc;
            bit cv;
            rvc = int'($urandom_range(0, NV - 1));
            cv  = (mcnt[rvc] < DEPTH) && ($urandom_range(0, 2) != 0);
            cycle(($urandom_range(0, 3) != 0), int'($urandom_range(0, NV - 1)),
                  $urandom, cv, rvc, rdy);
        end
        chk("random_no_err", bus.credit_err, 1'b0);

        // Overflow on VC1: refill it, then return one more credit.
        for (int i = 0; i < DEPTH && mcnt[1] < DEPTH; i++) cycle(0, 0, 32'h0, 1, 1, rdy);
        cycle(0, 0, 32'h0, 1, 1, rdy);
        chk("overflow_err", bus.credit_err, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1, 1, 32'hC000 + i, 0, 0, rdy);
        chk("err_sticky", bus.credit_err, 1'b1);

        // Accept on VC3, then assert reset between edges.
        for (int i = 0; i < DEPTH && mcnt[3] == 0; i++) cycle(0, 0, 32'h0, 1, 3, rdy);
        cycle(1, 3, 32'hDEAD_BEEF, 0, 0, rdy);
        chk("vc3_on_link", bus.link_valid, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_link_valid", bus.link_valid, 1'b0);
        chk("async_link_vc", bus.link_vc, 2'd0);
        chk("async_link_data", bus.link_data, 32'h0);
        chk("async_credit_err", bus.credit_err, 1'b0);
        chk("async_avail", bus.credit_avail, 4'b1111);
        model_reset();
        bus.in_valid     = 1'b0;
        bus.credit_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Every VC holds exactly BUF_DEPTH credits after reset.
        for (int v = 0; v < NV; v++) begin
            cnt_ok = 0;
            for (int i = 0; i < DEPTH + 1; i++) begin
                cycle(1, v, 32'hE000 + v * 16 + i, 0, 0, rdy);
                if (rdy) cnt_ok++;
            end
            chk("post_reset_credits", cnt_ok, DEPTH);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
